// File: rtl/vga_framebuffer_writer_pkg.sv
// Shared constants, types and small helpers for the VGA framebuffer writer.
package vga_framebuffer_writer_pkg;

   localparam logic [2:0] MCB_INSTR_WRITE   = 3'b000;
   localparam int         SCREEN_W          = 256;
   localparam int         SCREEN_H          = 192;
   localparam int         CLEAR_BURST_WORDS = 32;
   localparam int         CLEAR_BURSTS      = 384;

   localparam logic [5:0] MCB_BL_SINGLE = 6'd0;
   localparam logic [5:0] MCB_BL_CLEAR  = 6'(CLEAR_BURST_WORDS - 1);

   typedef logic [7:0] coord_t;
   typedef logic [7:0] rgb_t;

   // Byte offset of the 32-bit word holding pixel (x, y), relative to pixel (0,0).
   function automatic logic [15:0] px_word_offset(input coord_t y, input coord_t x);
      return {y, x[7:2], 2'b00};
   endfunction

   // One-hot byte-lane select for a pixel's position inside its word.
   function automatic logic [3:0] lane_bit(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/vga_framebuffer_writer_if.sv
// Pixel write handshake between the pixel pipeline (master) and the writer (slave).
interface vga_framebuffer_writer_if;
   import vga_framebuffer_writer_pkg::*;

   logic   px_valid;
   logic   px_ready;
   coord_t px_x;
   coord_t px_y;
   rgb_t   px_rgb;

   modport master (output px_valid, output px_x, output px_y, output px_rgb, input px_ready);
   modport slave  (input px_valid, input px_x, input px_y, input px_rgb, output px_ready);

endinterface

// File: rtl/vga_framebuffer_writer.sv
// Coalesces single-pixel writes into 32-bit MCB word writes and performs
// full-screen clears with 32-word bursts.
module vga_framebuffer_writer
   import vga_framebuffer_writer_pkg::*;
#(
   parameter logic [29:0] BASE_ADDR     = 30'h0,
   parameter int          FLUSH_TIMEOUT = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           calib_done_i,
   vga_framebuffer_writer_if.slave        px,
   input  logic                           flush_i,
   input  logic                           clear_i,
   input  logic [7:0]                     clear_rgb_i,
   output logic                           busy_o,
   output logic                           error_o,
   output logic                           mem_cmd_en_o,
   output logic [2:0]                     mem_cmd_instr_o,
   output logic [5:0]                     mem_cmd_bl_o,
   output logic [29:0]                    mem_cmd_byte_addr_o,
   input  logic                           mem_cmd_empty_i,
   input  logic                           mem_cmd_full_i,
   output logic                           mem_wr_en_o,
   output logic [3:0]                     mem_wr_mask_o,
   output logic [31:0]                    mem_wr_data_o,
   input  logic                           mem_wr_full_i,
   input  logic                           mem_wr_empty_i,
   input  logic [6:0]                     mem_wr_count_i,
   input  logic                           mem_wr_underrun_i,
   input  logic                           mem_wr_error_i
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HOLD     = 3'd1,
      ST_WDATA    = 3'd2,
      ST_WCMD     = 3'd3,
      ST_CLR_DATA = 3'd4,
      ST_CLR_CMD  = 3'd5
   } state_t;

   localparam int               CNT_W     = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(FLUSH_TIMEOUT);

   state_t           state_q, state_d;
   logic [29:0]      waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wmask_q, wmask_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic [4:0]       word_q, word_d;
   logic [8:0]       burst_q, burst_d;
   logic             clear_pend_q, clear_pend_d;
   logic [7:0]       clr_rgb_q, clr_rgb_d;
   logic             error_q;

   logic [29:0]      px_waddr_s;
   logic             same_word_s;
   logic [3:0]       merged_mask_s;
   logic [31:0]      merged_data_s;
   logic             px_ready_s;
   logic             accept_s;
   logic             wr_push_s;
   logic             cmd_issue_s;

   // FIFO level/empty flags are only observed for debug, not for control.
   logic             unused_dbg_s;
   assign unused_dbg_s = ^{mem_cmd_empty_i, mem_wr_empty_i, mem_wr_count_i};

   // Word address of the offered pixel and its merge into the hold register.
   always_comb begin
      px_waddr_s    = BASE_ADDR + {14'd0, px_word_offset(px.px_y, px.px_x)};
      same_word_s   = (px_waddr_s == waddr_q);
      merged_mask_s = wmask_q & ~lane_bit(px.px_x[1:0]);
      merged_data_s = wdata_q;
      merged_data_s[{px.px_x[1:0], 3'b000} +: 8] = px.px_rgb;
   end

   // Pixel acceptance: only while idle or holding the same word, never with a clear pending.
   always_comb begin
      case (state_q)
         ST_IDLE: px_ready_s = calib_done_i & ~clear_pend_q;
         ST_HOLD: px_ready_s = calib_done_i & same_word_s & ~clear_pend_q;
         default: px_ready_s = 1'b0;
      endcase
   end

   assign px.px_ready = px_ready_s;
   assign accept_s    = px.px_valid & px_ready_s;
   assign wr_push_s   = calib_done_i & ~mem_wr_full_i &
                        ((state_q == ST_WDATA) | (state_q == ST_CLR_DATA));
   assign cmd_issue_s = calib_done_i & ~mem_cmd_full_i &
                        ((state_q == ST_WCMD) | (state_q == ST_CLR_CMD));
   assign busy_o      = ~((state_q == ST_IDLE) & ~clear_pend_q);
   assign error_o     = error_q;

   // Next-state logic for the control FSM, hold register, clear request and counters.
   always_comb begin
      state_d      = state_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      tmo_d        = tmo_q;
      word_d       = word_q;
      burst_d      = burst_q;
      clear_pend_d = clear_pend_q;
      clr_rgb_d    = clr_rgb_q;

      // A second clear before the first has completed is dropped.
      if (clear_i && !clear_pend_q) begin
         clear_pend_d = 1'b1;
         clr_rgb_d    = clear_rgb_i;
      end else begin
         clear_pend_d = clear_pend_q;
      end

      if (accept_s) begin
         waddr_d = px_waddr_s;
         wdata_d = merged_data_s;
         wmask_d = merged_mask_s;
         tmo_d   = {CNT_W{1'b0}};
      end else begin
         tmo_d   = tmo_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (flush_i || (merged_mask_s == 4'h0)) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d = ST_HOLD;
               end
            end else if (clear_pend_q) begin
               state_d = ST_CLR_DATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (accept_s) begin
               if (flush_i || (merged_mask_s == 4'h0)) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d = ST_HOLD;
               end
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
               if (flush_i || (px.px_valid && !same_word_s) || clear_pend_q ||
                   ((tmo_q + CNT_W'(1)) == TIMEOUT_C)) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_WDATA: begin
            if (wr_push_s) begin
               state_d = ST_WCMD;
            end else begin
               state_d = ST_WDATA;
            end
         end
         ST_WCMD: begin
            if (cmd_issue_s) begin
               wmask_d = 4'hF;
               wdata_d = 32'h0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WCMD;
            end
         end
         ST_CLR_DATA: begin
            if (wr_push_s) begin
               if (word_q == 5'(CLEAR_BURST_WORDS - 1)) begin
                  word_d  = 5'd0;
                  state_d = ST_CLR_CMD;
               end else begin
                  word_d  = word_q + 5'd1;
               end
            end else begin
               state_d = ST_CLR_DATA;
            end
         end
         ST_CLR_CMD: begin
            if (cmd_issue_s) begin
               if (burst_q == 9'(CLEAR_BURSTS - 1)) begin
                  burst_d      = 9'd0;
                  clear_pend_d = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  burst_d      = burst_q + 9'd1;
                  state_d      = ST_CLR_DATA;
               end
            end else begin
               state_d = ST_CLR_CMD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // MCB strobes and buses, driven from registered state and the FIFO-full flags.
   always_comb begin
      mem_wr_en_o         = 1'b0;
      mem_wr_mask_o       = wmask_q;
      mem_wr_data_o       = wdata_q;
      mem_cmd_en_o        = 1'b0;
      mem_cmd_instr_o     = MCB_INSTR_WRITE;
      mem_cmd_bl_o        = 6'd0;
      mem_cmd_byte_addr_o = 30'h0;
      case (state_q)
         ST_WDATA: begin
            mem_wr_en_o = wr_push_s;
         end
         ST_WCMD: begin
            mem_cmd_en_o        = cmd_issue_s;
            mem_cmd_bl_o        = MCB_BL_SINGLE;
            mem_cmd_byte_addr_o = waddr_q;
         end
         ST_CLR_DATA: begin
            mem_wr_en_o   = wr_push_s;
            mem_wr_mask_o = 4'h0;
            mem_wr_data_o = {4{clr_rgb_q}};
         end
         ST_CLR_CMD: begin
            mem_cmd_en_o        = cmd_issue_s;
            mem_cmd_bl_o        = MCB_BL_CLEAR;
            mem_cmd_byte_addr_o = BASE_ADDR + {14'd0, burst_q, 7'd0};
         end
         default: begin
            mem_wr_en_o = 1'b0;
         end
      endcase
   end

   // State, hold register, counters and the sticky MCB error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         waddr_q      <= 30'h0;
         wdata_q      <= 32'h0;
         wmask_q      <= 4'hF;
         tmo_q        <= {CNT_W{1'b0}};
         word_q       <= 5'd0;
         burst_q      <= 9'd0;
         clear_pend_q <= 1'b0;
         clr_rgb_q    <= 8'h00;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         tmo_q        <= tmo_d;
         word_q       <= word_d;
         burst_q      <= burst_d;
         clear_pend_q <= clear_pend_d;
         clr_rgb_q    <= clr_rgb_d;
         error_q      <= error_q | mem_wr_underrun_i | mem_wr_error_i;
      end
   end

endmodule

// File: tb/tb_vga_framebuffer_writer.sv
// Self-checking bench: a screen-image model of what the pixel writes and clears
// should leave in video memory, compared against a model of the MCB that
// applies the DUT's pushes and commands, plus cycle-level latency checks.
module tb_vga_framebuffer_writer;
   import vga_framebuffer_writer_pkg::*;

   localparam logic [29:0] BASE   = 30'h0002_0000;
   localparam int          FT     = 8;
   localparam int          NBYTES = SCREEN_W * SCREEN_H;

   logic clk = 1'b0;
   logic rst, calib_done, flush, clear;
   logic [7:0] clear_rgb;
   logic mem_cmd_en, mem_wr_en, busy, error;
   logic [2:0] mem_cmd_instr;
   logic [5:0] mem_cmd_bl;
   logic [29:0] mem_cmd_byte_addr;
   logic [3:0] mem_wr_mask;
   logic [31:0] mem_wr_data;
   logic mem_cmd_full, mem_wr_full, mem_wr_underrun, mem_wr_error;

   vga_framebuffer_writer_if px_if ();

   vga_framebuffer_writer #(.BASE_ADDR(BASE), .FLUSH_TIMEOUT(FT)) dut (
      .clk(clk), .rst(rst), .calib_done_i(calib_done), .px(px_if),
      .flush_i(flush), .clear_i(clear), .clear_rgb_i(clear_rgb),
      .busy_o(busy), .error_o(error),
      .mem_cmd_en_o(mem_cmd_en), .mem_cmd_instr_o(mem_cmd_instr), .mem_cmd_bl_o(mem_cmd_bl),
      .mem_cmd_byte_addr_o(mem_cmd_byte_addr), .mem_cmd_empty_i(1'b1), .mem_cmd_full_i(mem_cmd_full),
      .mem_wr_en_o(mem_wr_en), .mem_wr_mask_o(mem_wr_mask), .mem_wr_data_o(mem_wr_data),
      .mem_wr_full_i(mem_wr_full), .mem_wr_empty_i(1'b1), .mem_wr_count_i(7'd0),
      .mem_wr_underrun_i(mem_wr_underrun), .mem_wr_error_i(mem_wr_error)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [7:0] exp_screen [0:NBYTES-1];
   logic [7:0] mem_model  [0:NBYTES-1];
   logic [35:0] wq [$];
   logic [35:0] mon_w;
   int mon_idx;
   int n_push = 0, n_cmd = 0, last_push_cyc = 0, last_cmd_cyc = 0;
   logic [31:0] last_push_data;
   logic [3:0]  last_push_mask;
   logic [29:0] last_cmd_addr;
   logic [5:0]  last_cmd_bl;
   logic [2:0]  last_cmd_instr;
   int mon_bad = 0, clr_idx = 0, clr_bad = 0;
   bit bp_en = 1'b0;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Random FIFO backpressure when enabled.
   initial forever begin
      @(posedge clk); #1;
      if (bp_en) begin
         mem_wr_full  = ($urandom_range(0, 3) == 0);
         mem_cmd_full = ($urandom_range(0, 3) == 0);
      end
   end

   // MCB model: queue pushed words, write them into memory when a command consumes them.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (mem_wr_en) begin
            wq.push_back({mem_wr_mask, mem_wr_data});
            n_push++; last_push_cyc = cyc; last_push_data = mem_wr_data; last_push_mask = mem_wr_mask;
         end
         if (mem_cmd_en) begin
            n_cmd++; last_cmd_cyc = cyc; last_cmd_addr = mem_cmd_byte_addr;
            last_cmd_bl = mem_cmd_bl; last_cmd_instr = mem_cmd_instr;
            if (wq.size() < int'(mem_cmd_bl) + 1) mon_bad++;
            else for (int i = 0; i <= int'(mem_cmd_bl); i++) begin
               mon_w = wq.pop_front();
               for (int b = 0; b < 4; b++) begin
                  mon_idx = int'(mem_cmd_byte_addr - BASE) + 4 * i + b;
                  if (mon_idx < 0 || mon_idx >= NBYTES) mon_bad++;
                  else if (!mon_w[32 + b]) mem_model[mon_idx] = mon_w[8 * b +: 8];
               end
            end
            if (mem_cmd_bl == 6'd31) begin
               if (mem_cmd_byte_addr !== BASE + 30'(clr_idx * 128)) clr_bad++;
               clr_idx = (clr_idx + 1) % CLEAR_BURSTS;
            end
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask

   task automatic reset_dut();
      rst = 1'b1; calib_done = 1'b0; flush = 1'b0; clear = 1'b0; clear_rgb = 8'h00;
      px_if.px_valid = 1'b0; px_if.px_x = 8'h00; px_if.px_y = 8'h00; px_if.px_rgb = 8'h00;
      mem_cmd_full = 1'b0; mem_wr_full = 1'b0; mem_wr_underrun = 1'b0; mem_wr_error = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] rgb,
                          input bit with_flush, input bit with_clear, output int acc_cyc);
      int waited = 0;
      px_if.px_valid = 1'b1; px_if.px_x = x; px_if.px_y = y; px_if.px_rgb = rgb;
      flush = with_flush; clear = with_clear;
      acc_cyc = -1;
      while (acc_cyc < 0) begin
         @(negedge clk);
         if (px_if.px_ready) acc_cyc = cyc;
         else if (++waited > 200) break;
      end
      n_checks++;
      if (acc_cyc < 0) begin
         n_errors++; $display("FAIL px_accept_timeout: pixel (%0d,%0d) not accepted, expected accept within 200 cycles", x, y);
      end else begin
         exp_screen[int'(y) * SCREEN_W + int'(x)] = rgb;
      end
      tick();
      flush = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n <= budget);
      n_checks++;
      if (busy) begin n_errors++; $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget); end
      tick();
   endtask

   task automatic compare_screen(input string name);
      int mism = 0, first = -1;
      for (int i = 0; i < NBYTES; i++) if (mem_model[i] !== exp_screen[i]) begin mism++; if (first < 0) first = i; end
      n_checks++;
      if (mism != 0) begin
         n_errors++;
         $display("FAIL %s: %0d bytes differ, first at %0d got %h expected %h", name, mism, first, mem_model[first], exp_screen[first]);
      end
      n_checks++;
      if (mon_bad != 0) begin n_errors++; $display("FAIL %s_mcb_protocol: %0d bad commands, expected 0", name, mon_bad); end
   endtask

   task automatic test_reset();
      reset_dut();
      @(negedge clk);
      n_checks++; if (px_if.px_ready !== 1'b0) begin n_errors++; $display("FAIL reset_px_ready: got %b expected 0", px_if.px_ready); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b expected 0", error); end
      n_checks++; if (mem_cmd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got cmd %b wr %b expected 0 0", mem_cmd_en, mem_wr_en); end
      n_checks++; if (mem_wr_mask !== 4'hF) begin n_errors++; $display("FAIL reset_mask: got %h expected f", mem_wr_mask); end
      n_checks++; if (mem_wr_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", mem_wr_data); end
      n_checks++; if (mem_cmd_bl !== 6'd0 || mem_cmd_instr !== 3'd0) begin n_errors++; $display("FAIL reset_cmd: got bl %0d instr %0d expected 0 0", mem_cmd_bl, mem_cmd_instr); end
      n_checks++; if (mem_cmd_byte_addr !== 30'h0) begin n_errors++; $display("FAIL reset_addr: got %h expected 0", mem_cmd_byte_addr); end
      tick(); rst = 1'b0; calib_done = 1'b1;
      @(negedge clk);
      n_checks++; if (px_if.px_ready !== 1'b1) begin n_errors++; $display("FAIL idle_px_ready: got %b expected 1", px_if.px_ready); end
      tick();
   endtask

   task automatic test_full_word();
      int acc[4];
      int p0 = n_push, c0 = n_cmd;
      logic [31:0] ed = 32'h0;
      for (int i = 0; i < 4; i++) begin
         send_px(8'(8 + i), 8'd5, 8'(i + 1), 1'b0, 1'b0, acc[i]);
         ed[8 * ((8 + i) % 4) +: 8] = 8'(i + 1);
      end
      px_if.px_valid = 1'b0;
      wait_idle(100);
      n_checks++; if (acc[3] - acc[0] != 3) begin n_errors++; $display("FAIL full_b2b: accepts spanned %0d cycles expected 3", acc[3] - acc[0]); end
      n_checks++; if (n_push - p0 != 1 || n_cmd - c0 != 1) begin n_errors++; $display("FAIL full_counts: got %0d pushes %0d cmds expected 1 1", n_push - p0, n_cmd - c0); end
      n_checks++; if (last_push_data !== ed || last_push_mask !== 4'h0) begin n_errors++; $display("FAIL full_data: got %h/%h expected %h/0", last_push_data, last_push_mask, ed); end
      n_checks++; if (last_push_cyc != acc[3] + 1) begin n_errors++; $display("FAIL full_latency: push at +%0d expected +1", last_push_cyc - acc[3]); end
      n_checks++; if (last_cmd_addr !== BASE + 30'(5 * 256 + 8) || last_cmd_bl !== 6'd0 || last_cmd_instr !== 3'd0) begin
         n_errors++; $display("FAIL full_cmd: got addr %h bl %0d instr %0d expected %h 0 0", last_cmd_addr, last_cmd_bl, last_cmd_instr, BASE + 30'(5 * 256 + 8)); end
   endtask

   task automatic test_timeout();
      int acc;
      send_px(8'd7, 8'd0, 8'hAA, 1'b0, 1'b0, acc);
      px_if.px_valid = 1'b0;
      wait_idle(100);
      n_checks++; if (last_push_cyc - acc != FT + 1) begin n_errors++; $display("FAIL timeout_latency: push at +%0d expected +%0d", last_push_cyc - acc, FT + 1); end
      n_checks++; if (last_push_data[31:24] !== 8'hAA || last_push_mask !== 4'b0111) begin n_errors++; $display("FAIL timeout_data: got %h/%b expected aa in byte3/0111", last_push_data, last_push_mask); end
      n_checks++; if (last_cmd_addr !== BASE + 30'd4) begin n_errors++; $display("FAIL timeout_addr: got %h expected %h", last_cmd_addr, BASE + 30'd4); end
   endtask

   task automatic test_stall();
      int a1, a2, c1;
      send_px(8'd0, 8'd0, 8'h11, 1'b0, 1'b0, a1);
      send_px(8'd4, 8'd0, 8'h22, 1'b0, 1'b0, a2);
      c1 = last_cmd_cyc;
      px_if.px_valid = 1'b0;
      wait_idle(100);
      n_checks++; if (a2 - a1 != 4) begin n_errors++; $display("FAIL stall_gap: second accept at +%0d expected +4", a2 - a1); end
      n_checks++; if (a2 != c1 + 1) begin n_errors++; $display("FAIL stall_after_cmd: accept at %0d expected %0d", a2, c1 + 1); end
   endtask

   task automatic test_flush();
      int acc, fcyc, rdy = -1;
      send_px(8'd20, 8'd10, 8'h33, 1'b0, 1'b0, acc);
      px_if.px_valid = 1'b0; flush = 1'b1; fcyc = cyc;
      tick(); flush = 1'b0;
      for (int i = 0; i < 20 && rdy < 0; i++) begin @(negedge clk); if (px_if.px_ready) rdy = cyc; end
      n_checks++; if (last_push_cyc != fcyc + 1) begin n_errors++; $display("FAIL flush_push: at +%0d expected +1", last_push_cyc - fcyc); end
      n_checks++; if (last_cmd_cyc != fcyc + 2) begin n_errors++; $display("FAIL flush_cmd: at +%0d expected +2", last_cmd_cyc - fcyc); end
      n_checks++; if (rdy != fcyc + 3) begin n_errors++; $display("FAIL flush_ready: at +%0d expected +3", rdy - fcyc); end
      tick();
      send_px(8'd40, 8'd10, 8'h44, 1'b1, 1'b0, acc);
      px_if.px_valid = 1'b0;
      wait_idle(100);
      n_checks++; if (last_push_cyc != acc + 1 || last_push_data[7:0] !== 8'h44 || last_push_mask !== 4'b1110) begin
         n_errors++; $display("FAIL flush_same_cycle: push +%0d data %h mask %b expected +1 byte0 44 mask 1110", last_push_cyc - acc, last_push_data, last_push_mask); end
   endtask

   task automatic test_backpressure();
      int acc, fcyc, p0, pstall;
      send_px(8'd60, 8'd20, 8'h55, 1'b0, 1'b0, acc);
      px_if.px_valid = 1'b0; flush = 1'b1; mem_wr_full = 1'b1; fcyc = cyc; p0 = n_push;
      tick(); flush = 1'b0;
      repeat (10) tick();
      pstall = n_push; mem_wr_full = 1'b0;
      wait_idle(100);
      n_checks++; if (pstall != p0) begin n_errors++; $display("FAIL bp_stall: %0d pushes while full expected 0", pstall - p0); end
      n_checks++; if (last_push_cyc != fcyc + 11 || last_cmd_cyc != fcyc + 12) begin
         n_errors++; $display("FAIL bp_latency: push +%0d cmd +%0d expected +11 +12", last_push_cyc - fcyc, last_cmd_cyc - fcyc); end
      n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL err_before: got %b expected 0", error); end
      mem_wr_error = 1'b1; tick(); mem_wr_error = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b expected 1", error); end
      tick();
   endtask

   task automatic test_calib();
      int acc, bad = 0, p0;
      calib_done = 1'b0;
      px_if.px_valid = 1'b1; px_if.px_x = 8'd120; px_if.px_y = 8'd50; px_if.px_rgb = 8'h67;
      repeat (4) begin @(negedge clk); if (px_if.px_ready) bad++; end
      n_checks++; if (bad != 0) begin n_errors++; $display("FAIL calib_ready: px_ready high %0d cycles expected 0", bad); end
      tick(); calib_done = 1'b1;
      send_px(8'd120, 8'd50, 8'h67, 1'b0, 1'b0, acc);
      px_if.px_valid = 1'b0; calib_done = 1'b0; flush = 1'b1; p0 = n_push;
      tick(); flush = 1'b0;
      repeat (6) tick();
      n_checks++; if (n_push != p0 || busy !== 1'b1) begin n_errors++; $display("FAIL calib_hold: pushes %0d busy %b expected 0 1", n_push - p0, busy); end
      calib_done = 1'b1;
      wait_idle(100);
      n_checks++; if (n_push != p0 + 1 || last_push_data[7:0] !== 8'h67) begin n_errors++; $display("FAIL calib_resume: pushes %0d byte0 %h expected 1 67", n_push - p0, last_push_data[7:0]); end
   endtask

   task automatic test_random();
      int acc;
      logic [7:0] x = 8'd0, y = 8'd0;
      bp_en = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            x = {x[7:2], 2'($urandom_range(0, 3))};
         end else begin
            x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, SCREEN_H - 1));
         end
         send_px(x, y, 8'($urandom), ($urandom_range(0, 15) == 0), 1'b0, acc);
         if ($urandom_range(0, 5) == 0) begin
            px_if.px_valid = 1'b0;
            calib_done = ($urandom_range(0, 2) != 0);
            repeat ($urandom_range(1, FT + 4)) tick();
            calib_done = 1'b1;
         end
      end
      px_if.px_valid = 1'b0;
      wait_idle(200);
      bp_en = 1'b0; tick(); mem_wr_full = 1'b0; mem_cmd_full = 1'b0;
      compare_screen("random_screen");
   endtask

   task automatic test_clear_with_pixel();
      int acc;
      clear_rgb = 8'hE3;
      send_px(8'd3, 8'd3, 8'h99, 1'b0, 1'b1, acc);
      px_if.px_valid = 1'b0;
      for (int i = 0; i < NBYTES; i++) exp_screen[i] = 8'hE3;
      wait_idle(20000);
      compare_screen("clear_px_screen");
   endtask

   task automatic test_clear();
      int p0 = n_push, c0 = n_cmd, ccyc, low = -1;
      clr_idx = 0; clr_bad = 0;
      clear_rgb = 8'h1C; clear = 1'b1; ccyc = cyc;
      tick(); clear = 1'b0;
      repeat (100) tick();
      clear_rgb = 8'h55; clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 20000 && low < 0; i++) begin @(negedge clk); if (!busy) low = cyc; end
      for (int i = 0; i < NBYTES; i++) exp_screen[i] = 8'h1C;
      n_checks++; if (n_cmd - c0 != CLEAR_BURSTS) begin n_errors++; $display("FAIL clear_cmds: got %0d expected %0d", n_cmd - c0, CLEAR_BURSTS); end
      n_checks++; if (n_push - p0 != CLEAR_BURSTS * CLEAR_BURST_WORDS) begin n_errors++; $display("FAIL clear_pushes: got %0d expected %0d", n_push - p0, CLEAR_BURSTS * CLEAR_BURST_WORDS); end
      n_checks++; if (clr_bad != 0) begin n_errors++; $display("FAIL clear_addrs: %0d misplaced bursts expected 0", clr_bad); end
      n_checks++; if (last_push_data !== 32'h1C1C1C1C || last_push_mask !== 4'h0) begin n_errors++; $display("FAIL clear_data: got %h/%h expected 1c1c1c1c/0", last_push_data, last_push_mask); end
      n_checks++; if (low != ccyc + CLEAR_BURSTS * 33 + 2) begin n_errors++; $display("FAIL clear_duration: busy low at +%0d expected +%0d", low - ccyc, CLEAR_BURSTS * 33 + 2); end
      tick();
      compare_screen("clear_screen");
   endtask

   task automatic test_error_reset();
      reset_dut();
      rst = 1'b0; calib_done = 1'b1;
      @(negedge clk);
      n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL err_after_rst: got %b expected 0", error); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < NBYTES; i++) begin exp_screen[i] = 8'h00; mem_model[i] = 8'h00; end
      test_reset();
      test_full_word();
      test_timeout();
      test_stall();
      test_flush();
      test_backpressure();
      test_calib();
      test_random();
      test_clear_with_pixel();
      test_clear();
      test_error_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
